// File: rtl/tick_mon_pkg.sv
// rtl/tick_mon_pkg.sv - shared types and default constants for the tick timeout monitor
//
// Purpose: FSM state encoding and default timing constants used by
// tick_timeout_monitor and tick_gap_checker.
// Ports: none (package).

package tick_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    TMO  = 2'd3
  } state_e;

  // Generator period N+1 with N = 15000.
  localparam int unsigned TICK_GAP_MAX_D  = 15001;
  localparam int unsigned TIMEOUT_TICKS_D = 8;

endpackage

// File: rtl/tick_gap_checker.sv
// rtl/tick_gap_checker.sv - liveness and pulse-shape watchdog for the tick stream
//
// Purpose: measures clk cycles between ticks and flags a stalled tick stream
// (tick_lost) or a tick held high on two consecutive cycles (tick_dup).
// Both flags are sticky until rst_n.
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   tick      - one-cycle timebase pulse
//   tick_lost - sticky, gap between ticks reached TICK_GAP_MAX
//   tick_dup  - sticky, tick seen high on two consecutive cycles

module tick_gap_checker
  import tick_mon_pkg::*;
#(
  parameter int unsigned TICK_GAP_MAX = TICK_GAP_MAX_D,
  parameter int unsigned GBITS        = 14
) (
  input  logic clk,
  input  logic rst_n,
  input  logic tick,
  output logic tick_lost,
  output logic tick_dup
);

  localparam logic [GBITS-1:0] GAP_SAT  = GBITS'(TICK_GAP_MAX);
  localparam logic [GBITS-1:0] GAP_LAST = GBITS'(TICK_GAP_MAX - 1);

  logic [GBITS-1:0] gap_cnt_q, gap_cnt_d;
  logic             tick_q;
  logic             tick_lost_q, tick_lost_d;
  logic             tick_dup_q, tick_dup_d;

  always_comb begin
    gap_cnt_d = gap_cnt_q;
    if (tick) begin
      gap_cnt_d = '0;
    end else if (gap_cnt_q != GAP_SAT) begin
      gap_cnt_d = gap_cnt_q + GBITS'(1);
    end
    // A tick arriving exactly when the gap reaches TICK_GAP_MAX-1 is still on
    // time, so a healthy generator with period TICK_GAP_MAX never trips this.
    tick_lost_d = tick_lost_q | (!tick && (gap_cnt_q == GAP_LAST));
    tick_dup_d  = tick_dup_q | (tick && tick_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gap_cnt_q   <= '0;
      tick_q      <= 1'b0;
      tick_lost_q <= 1'b0;
      tick_dup_q  <= 1'b0;
    end else begin
      gap_cnt_q   <= gap_cnt_d;
      tick_q      <= tick;
      tick_lost_q <= tick_lost_d;
      tick_dup_q  <= tick_dup_d;
    end
  end

  assign tick_lost = tick_lost_q;
  assign tick_dup  = tick_dup_q;

endmodule

// File: rtl/tick_timeout_monitor.sv
// rtl/tick_timeout_monitor.sv - req/ack transaction bounded by a tick count, plus tick stream watchdog
//
// Purpose: runs one req/ack transaction at a time, aborting it after
// TIMEOUT_TICKS ticks or when the tick stream is lost, and reports tick
// stream faults. All outputs are registered.
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset
//   tick      - one-cycle timebase pulse
//   start     - begin a transaction (sampled in IDLE)
//   ack       - far-side response (sampled in WAIT)
//   req       - high throughout WAIT
//   done      - one-cycle pulse, transaction acknowledged
//   timeout   - one-cycle pulse, transaction aborted
//   tick_lost - sticky, tick gap exceeded
//   tick_dup  - sticky, tick high on two consecutive cycles
//   tick_cnt  - ticks seen in the current (or last) WAIT

module tick_timeout_monitor
  import tick_mon_pkg::*;
#(
  parameter int unsigned TICK_GAP_MAX  = TICK_GAP_MAX_D,
  parameter int unsigned GBITS         = 14,
  parameter int unsigned TIMEOUT_TICKS = TIMEOUT_TICKS_D,
  parameter int unsigned TBITS         = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             start,
  input  logic             ack,
  output logic             req,
  output logic             done,
  output logic             timeout,
  output logic             tick_lost,
  output logic             tick_dup,
  output logic [TBITS-1:0] tick_cnt
);

  localparam logic [TBITS-1:0] CNT_LAST = TBITS'(TIMEOUT_TICKS - 1);

  state_e           state_q, state_d;
  logic             req_q, req_d;
  logic             done_q, done_d;
  logic             timeout_q, timeout_d;
  logic [TBITS-1:0] tick_cnt_q, tick_cnt_d;
  logic             lost;

  tick_gap_checker #(
    .TICK_GAP_MAX (TICK_GAP_MAX),
    .GBITS        (GBITS)
  ) u_gap (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .tick_lost (lost),
    .tick_dup  (tick_dup)
  );

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d    = WAIT;
          tick_cnt_d = '0;
        end
      end
      WAIT: begin
        // ack outranks everything, including an expiring tick on the same edge;
        // a lost tick stream aborts before the tick count is considered.
        if (ack) begin
          state_d = DONE;
        end else if (lost) begin
          state_d = TMO;
        end else if (tick) begin
          tick_cnt_d = tick_cnt_q + TBITS'(1);
          if (tick_cnt_q == CNT_LAST) begin
            state_d = TMO;
          end
        end
      end
      DONE:    state_d = IDLE;
      TMO:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they line up with state_q.
    req_d     = (state_d == WAIT);
    done_d    = (state_d == DONE);
    timeout_d = (state_d == TMO);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      tick_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      tick_cnt_q <= tick_cnt_d;
    end
  end

  assign req       = req_q;
  assign done      = done_q;
  assign timeout   = timeout_q;
  assign tick_lost = lost;
  assign tick_cnt  = tick_cnt_q;

  a_done_tmo_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(done_q && timeout_q));

  a_req_only_wait: assert property (@(posedge clk) disable iff (!rst_n)
    req_q |-> (state_q == WAIT));

`ifdef FORMAL
  // A live tick stream (no loss) bounds every WAIT by TIMEOUT_TICKS periods.
  m_tick_alive: assume property (@(posedge clk) disable iff (!rst_n) !lost);

  a_req_live: assert property (@(posedge clk) disable iff (!rst_n)
    req_q |-> s_eventually (done_q || timeout_q));
`endif

endmodule

// File: tb/tb_tick_timeout_monitor.sv
// tb/tb_tick_timeout_monitor.sv - scoreboard bench for tick_timeout_monitor

`timescale 1ns/1ps

module tb_tick_timeout_monitor;
  import tick_mon_pkg::*;

  localparam int PER = 40;
  localparam int TO  = 8;

  logic       clk = 1'b0;
  logic       rst_n, tick, start, ack;
  logic       req, done, timeout, tick_lost, tick_dup;
  logic [3:0] tick_cnt;

  always #5 clk = ~clk;

  tick_timeout_monitor #(
    .TICK_GAP_MAX  (PER),
    .GBITS         (6),
    .TIMEOUT_TICKS (TO),
    .TBITS         (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .start     (start),
    .ack       (ack),
    .req       (req),
    .done      (done),
    .timeout   (timeout),
    .tick_lost (tick_lost),
    .tick_dup  (tick_dup),
    .tick_cnt  (tick_cnt)
  );

  typedef struct {
    int cyc;
    bit is_done;
    int cnt;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_errs   = 0;
  int   cyc      = 0;
  bit   tick_on  = 1'b0;
  int   tgen     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_exp(input int c, input bit d, input int k);
    exp_t e;
    e.cyc     = c;
    e.is_done = d;
    e.cnt     = k;
    sb.push_back(e);
  endtask

  // Advance one clock; inputs set after return are sampled on the next edge.
  task automatic cycle();
    @(posedge clk);
    #1;
    start = 1'b0;
    ack   = 1'b0;
    tgen++;
    if (tick_on && tgen >= PER) begin
      tick = 1'b1;
      tgen = 0;
    end else begin
      tick = 1'b0;
    end
  endtask

  task automatic wait_tick();
    int g;
    g = 0;
    do begin
      cycle();
      g++;
    end while (tick !== 1'b1 && g < 4 * PER);
    check_val("tick_seen", tick, 1);
  endtask

  // Every done/timeout pulse must match the oldest expected transaction end.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && (done === 1'b1 || timeout === 1'b1)) begin
      check_val("pulse_excl", done & timeout, 0);
      if (sb.size() == 0) begin
        check_val("unexpected_pulse", sb.size(), 1);
      end else begin
        mon_e = sb.pop_front();
        check_val("pulse_cyc", cyc, mon_e.cyc);
        check_val("pulse_is_done", done, mon_e.is_done);
        check_val("pulse_tick_cnt", tick_cnt, mon_e.cnt);
      end
    end
  end

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int n, guard, l0;
    rst_n = 1'b0;
    tick  = 1'b0;
    start = 1'b0;
    ack   = 1'b0;
    repeat (3) cycle();
    check_val("rst_req", req, 0);
    check_val("rst_done", done, 0);
    check_val("rst_timeout", timeout, 0);
    check_val("rst_tick_lost", tick_lost, 0);
    check_val("rst_tick_dup", tick_dup, 0);
    check_val("rst_tick_cnt", tick_cnt, 0);

    rst_n   = 1'b1;
    tgen    = PER - 10;
    tick_on = 1'b1;

    // Five healthy tick periods, no transaction.
    n = 0;
    for (int i = 0; i < 5 * PER; i++) begin
      cycle();
      if (req === 1'b1) n++;
    end
    check_val("idle_req_cycles", n, 0);
    check_val("idle_tick_lost", tick_lost, 0);
    check_val("idle_tick_dup", tick_dup, 0);

    // start, ack 20 cycles later, no tick in between.
    wait_tick();
    cycle();
    start = 1'b1;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (req === 1'b1) n++;
    end
    check_val("wait_req_cycles", n, 20);
    ack = 1'b1;
    push_exp(cyc + 1, 1'b1, 0);
    cycle();
    check_val("ack_req_drop", req, 0);
    cycle();

    // Back-to-back minimum-length transactions.
    for (int k = 0; k < 2; k++) begin
      start = 1'b1;
      cycle();
      check_val("b2b_req", req, 1);
      ack = 1'b1;
      push_exp(cyc + 1, 1'b1, 0);
      cycle();
      cycle();
    end

    // No ack: timeout the cycle after the TO-th tick.
    start = 1'b1;
    n = 0;
    guard = 0;
    while (n < TO && guard < 20 * PER) begin
      cycle();
      guard++;
      if (tick === 1'b1) n++;
    end
    check_val("tmo_req_before", req, 1);
    push_exp(cyc + 1, 1'b0, TO);
    cycle();
    check_val("tmo_req_drop", req, 0);
    check_val("tmo_tick_cnt", tick_cnt, TO);
    cycle();

    // ack on the same edge as the TO-th tick: done wins.
    start = 1'b1;
    n = 0;
    guard = 0;
    while (n < TO && guard < 20 * PER) begin
      cycle();
      guard++;
      if (tick === 1'b1) n++;
    end
    ack = 1'b1;
    push_exp(cyc + 1, 1'b1, TO - 1);
    cycle();
    cycle();

    // Ticks stop after two periods in WAIT.
    start = 1'b1;
    n = 0;
    guard = 0;
    while (n < 2 && guard < 4 * PER) begin
      cycle();
      guard++;
      if (tick === 1'b1) n++;
    end
    tick_on = 1'b0;
    l0 = cyc + 1;
    push_exp(l0 + PER + 1, 1'b0, 2);
    while (cyc < l0 + PER + 3) begin
      cycle();
      if (cyc == l0 + PER - 1) check_val("lost_before", tick_lost, 0);
      if (cyc == l0 + PER) check_val("lost_set", tick_lost, 1);
    end
    tick_on = 1'b1;
    tgen = 0;
    repeat (PER) cycle();
    check_val("lost_sticky", tick_lost, 1);
    tick_on = 1'b0;
    cycle();

    // start while tick_lost is set: enters WAIT then aborts.
    start = 1'b1;
    cycle();
    check_val("lost_start_req", req, 1);
    push_exp(cyc + 1, 1'b0, 0);
    cycle();
    cycle();

    rst_n = 1'b0;
    #1;
    check_val("rst_lost_clear", tick_lost, 0);
    cycle();
    rst_n = 1'b1;

    // Duplicate tick inside WAIT, then asynchronous reset mid-WAIT.
    start = 1'b1;
    cycle();
    tick = 1'b1;
    cycle();
    check_val("dup_single_tick", tick_dup, 0);
    tick = 1'b1;
    cycle();
    check_val("dup_set", tick_dup, 1);
    check_val("dup_wait_req", req, 1);
    check_val("dup_tick_cnt", tick_cnt, 2);
    cycle();
    check_val("dup_sticky", tick_dup, 1);

    #2 rst_n = 1'b0;
    #1;
    check_val("mid_rst_req", req, 0);
    check_val("mid_rst_done", done, 0);
    check_val("mid_rst_timeout", timeout, 0);
    check_val("mid_rst_tick_lost", tick_lost, 0);
    check_val("mid_rst_tick_dup", tick_dup, 0);
    check_val("mid_rst_tick_cnt", tick_cnt, 0);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();
    check_val("post_rst_state", dut.state_q, IDLE);
    check_val("post_rst_req", req, 0);
    start = 1'b1;
    cycle();
    check_val("post_rst_req_on", req, 1);
    ack = 1'b1;
    push_exp(cyc + 1, 1'b1, 0);
    cycle();
    cycle();
    cycle();

    check_val("sb_drain", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
